data_mem_stream_reader: RTL and testbench

Burst read engine on the data-memory read side. On a `start` pulse it fetches `word_count` consecutive 256-bit words from `data_mem` through one read port (`pointer1`/`data1`, `read_data`) and serializes each word into sixteen 16-bit matrix elements on a valid/ready stream. It sits between `data_mem` and the execute-stage element consumer, mirroring the write-side traffic that fills memory.

---
 rtl/data_mem_stream_pkg.sv | 23 ++
 rtl/data_mem_stream_reader_if.sv | 28 ++
 rtl/word_serializer.sv | 52 +++++
 rtl/data_mem_stream_reader.sv | 113 +++++++++++
 tb/tb_data_mem_stream_reader.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_stream_pkg.sv
// Shared types and constants for the data-memory burst reader.
package data_mem_stream_pkg;

  localparam int DEFAULT_WORD_W = 256;
  localparam int DEFAULT_ELEM_W = 16;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_DEPTH  = 6;
  localparam int ELEMS_PER_WORD = DEFAULT_WORD_W / DEFAULT_ELEM_W;
  localparam int IDX_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    STREAM
  } state_t;

  // A burst must start inside memory and cover between one and depth words.
  function automatic logic request_ok(input int ptr, input int count, input int depth);
    return (count >= 1) && (count <= depth) && (ptr < depth);
  endfunction

endpackage

// File: rtl/data_mem_stream_reader_if.sv
// Memory read port and element stream of the burst reader, bundled together.
interface data_mem_stream_reader_if
  import data_mem_stream_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int ELEM_W = DEFAULT_ELEM_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [ADDR_W-1:0] mem_pointer;
  logic              mem_read;
  logic [WORD_W-1:0] mem_data;
  logic [ELEM_W-1:0] elem_out;
  logic              elem_valid;
  logic              elem_ready;
  logic              elem_last;

  modport master (
    output mem_pointer, mem_read, elem_out, elem_valid, elem_last,
    input  mem_data, elem_ready
  );

  modport slave (
    input  mem_pointer, mem_read, elem_out, elem_valid, elem_last,
    output mem_data, elem_ready
  );

endinterface

// File: rtl/word_serializer.sv
// Holds one memory word and presents it as a valid/ready stream of elements,
// lowest element first.
module word_serializer
  import data_mem_stream_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int ELEM_W = DEFAULT_ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] word,
  input  logic              ready,
  input  logic              last_word,
  output logic [ELEM_W-1:0] elem,
  output logic              valid,
  output logic              last,
  output logic              word_done
);

  logic [WORD_W-1:0] buffer;
  logic [IDX_W-1:0]  idx;
  logic              final_elem;

  assign final_elem = (idx == IDX_W'(ELEMS_PER_WORD - 1));
  assign word_done  = valid && ready && final_elem;
  assign elem       = buffer[int'(idx)*ELEM_W +: ELEM_W];
  assign last       = valid && last_word && final_elem;

  // Clear wins over load so an abort during WAIT leaves nothing to stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer <= '0;
      idx    <= '0;
      valid  <= 1'b0;
    end else if (clear) begin
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      buffer <= word;
      idx    <= '0;
      valid  <= 1'b1;
    end else if (valid && ready) begin
      idx <= idx + IDX_W'(1);
      if (final_elem) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_mem_stream_reader.sv
// Burst read engine: fetches consecutive words from data_mem and streams
// each one out as sixteen elements.
module data_mem_stream_reader
  import data_mem_stream_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int ELEM_W = DEFAULT_ELEM_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_ptr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  data_mem_stream_reader_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] words_left;
  logic              mem_read_q;
  logic              load;
  logic              clear;
  logic              last_word;
  logic              word_done;

  assign load      = (state == WAIT);
  assign clear     = abort && (state != IDLE);
  assign last_word = (words_left == ADDR_W'(1));

  assign bus.mem_pointer = ptr;
  assign bus.mem_read    = mem_read_q;

  word_serializer #(
    .WORD_W(WORD_W),
    .ELEM_W(ELEM_W)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .clear     (clear),
    .word      (bus.mem_data),
    .ready     (bus.elem_ready),
    .last_word (last_word),
    .elem      (bus.elem_out),
    .valid     (bus.elem_valid),
    .last      (bus.elem_last),
    .word_done (word_done)
  );

  // mem_read is raised on the edge that enters FETCH, so it is high for exactly
  // that one cycle and the pointer only moves when a new fetch begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      words_left <= '0;
      mem_read_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done       <= 1'b0;
      mem_read_q <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        busy       <= 1'b0;
        words_left <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (request_ok(int'(start_ptr), int'(word_count), DEPTH)) begin
                ptr        <= start_ptr;
                words_left <= word_count;
                err        <= 1'b0;
                busy       <= 1'b1;
                mem_read_q <= 1'b1;
                state      <= FETCH;
              end else begin
                err <= 1'b1;
              end
            end
          end
          FETCH:  state <= WAIT;
          WAIT:   state <= STREAM;
          STREAM: begin
            if (word_done) begin
              if (last_word) begin
                words_left <= '0;
                busy       <= 1'b0;
                done       <= 1'b1;
                state      <= IDLE;
              end else begin
                words_left <= words_left - ADDR_W'(1);
                ptr        <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
                mem_read_q <= 1'b1;
                state      <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_stream_reader.sv
// Self-checking bench for data_mem_stream_reader: random memory contents and
// random stalls compared against a word/element-level model of each burst.
module tb_data_mem_stream_reader;
  import data_mem_stream_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] start_ptr = '0;
  logic [2:0] word_count = '0;
  logic       busy;
  logic       done;
  logic       err;

  data_mem_stream_reader_if bus();

  data_mem_stream_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_ptr  (start_ptr),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory behind the read port.
  logic [255:0] mem [8];
  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_data <= mem[bus.mem_pointer];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] got_q[$];
  bit          got_last_q[$];
  logic [15:0] exp_q[$];
  bit          exp_last_q[$];
  logic [2:0]  ptr_seen[$];
  int mem_reads, done_cnt, stall_cycles, stall_breaks, first_valid, fetch_at, done_at;

  task automatic clear_rec();
    got_q.delete(); got_last_q.delete(); exp_q.delete(); exp_last_q.delete();
    ptr_seen.delete();
    mem_reads = 0; done_cnt = 0; stall_cycles = 0; stall_breaks = 0;
    first_valid = -1; fetch_at = -1; done_at = -1;
  endtask

  // Reference model: the element sequence a burst must produce.
  task automatic build_expected(input int ptr, input int cnt);
    for (int w = 0; w < cnt; w++) begin
      int a = (ptr + w) % DEFAULT_DEPTH;
      for (int e = 0; e < 16; e++) begin
        exp_q.push_back(mem[a][16*e +: 16]);
        exp_last_q.push_back(w == cnt - 1 && e == 15);
      end
    end
  endtask

  // Advance one clock, recording handshakes, stalls, reads and done pulses.
  task automatic cycle();
    bit hs, hold;
    logic [15:0] hv;
    logic hl;
    hs   = bus.elem_valid && bus.elem_ready;
    hold = bus.elem_valid && !bus.elem_ready && !abort;
    hv   = bus.elem_out;
    hl   = bus.elem_last;
    if (hs) begin
      got_q.push_back(bus.elem_out);
      got_last_q.push_back(bus.elem_last);
    end
    @(posedge clk); #1; cyc++;
    if (hold) begin
      stall_cycles++;
      if (bus.elem_valid !== 1'b1 || bus.elem_out !== hv || bus.elem_last !== hl) stall_breaks++;
    end
    if (bus.mem_read) begin
      mem_reads++;
      ptr_seen.push_back(bus.mem_pointer);
      if (fetch_at < 0) fetch_at = cyc;
    end
    if (bus.elem_valid && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_cnt++;
      if (done_at < 0) done_at = cyc;
    end
  endtask

  task automatic launch(input int ptr, input int cnt);
    start_ptr = 3'(ptr);
    word_count = 3'(cnt);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  function automatic int stream_errors();
    int n = 0;
    int m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    if (got_q.size() != exp_q.size()) n++;
    for (int i = 0; i < m; i++)
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, err, bus.mem_read, bus.elem_valid, bus.elem_last} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b, expected 000000",
               {busy, done, err, bus.mem_read, bus.elem_valid, bus.elem_last});
    end
    checks++;
    if (bus.mem_pointer !== 3'd0 || bus.elem_out !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_buses: got ptr=%0d elem=%h, expected 0/0000", bus.mem_pointer, bus.elem_out);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    bit ok;
    for (int e = 0; e < 16; e++) mem[2][16*e +: 16] = 16'(e);
    bus.elem_ready = 1'b1;
    clear_rec();
    build_expected(2, 1);
    launch(2, 1);
    checks++;
    if (busy !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_pointer !== 3'd2) begin
      failures++;
      $display("[TB] FAIL single_fetch: got busy=%b read=%b ptr=%0d, expected 1/1/2", busy, bus.mem_read, bus.mem_pointer);
    end
    run_until_done(1, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL single_done_timeout: got no done, expected done"); end
    checks++;
    if (first_valid - fetch_at != 2) begin
      failures++;
      $display("[TB] FAIL single_valid_latency: got %0d, expected 2", first_valid - fetch_at);
    end
    checks++;
    if (done_at - fetch_at != 18) begin
      failures++;
      $display("[TB] FAIL single_done_latency: got %0d, expected 18", done_at - fetch_at);
    end
    checks++;
    if (stream_errors() != 0) begin
      failures++;
      $display("[TB] FAIL single_stream: got %0d bad of %0d elems, expected 0 bad of %0d", stream_errors(), got_q.size(), exp_q.size());
    end
    cycle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_reads != 1) begin
      failures++;
      $display("[TB] FAIL single_after: got done=%b busy=%b reads=%0d, expected 0/0/1", done, busy, mem_reads);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int p1 = $urandom_range(0, 5);
    int p2 = $urandom_range(0, 5);
    clear_rec();
    build_expected(p1, 1);
    launch(p1, 1);
    run_until_done(1, 60, ok);
    build_expected(p2, 2);
    launch(p2, 2);
    checks++;
    if (bus.mem_read !== 1'b1 || busy !== 1'b1 || bus.mem_pointer !== 3'(p2)) begin
      failures++;
      $display("[TB] FAIL b2b_accept: got read=%b busy=%b ptr=%0d, expected 1/1/%0d", bus.mem_read, busy, bus.mem_pointer, p2);
    end
    run_until_done(2, 100, ok);
    checks++;
    if (!ok || stream_errors() != 0 || mem_reads != 3) begin
      failures++;
      $display("[TB] FAIL b2b_stream: got ok=%0d bad=%0d reads=%0d, expected 1/0/3", ok, stream_errors(), mem_reads);
    end
  endtask

  task automatic test_wrap_burst();
    bit ok;
    clear_rec();
    build_expected(4, 3);
    launch(4, 3);
    run_until_done(1, 200, ok);
    checks++;
    if (ptr_seen.size() != 3 || ptr_seen[0] !== 3'd4 || ptr_seen[1] !== 3'd5 || ptr_seen[2] !== 3'd0) begin
      failures++;
      $display("[TB] FAIL wrap_pointers: got %p, expected 4 5 0", ptr_seen);
    end
    checks++;
    if (stream_errors() != 0) begin
      failures++;
      $display("[TB] FAIL wrap_stream: got %0d bad of %0d elems, expected 0 bad of 48", stream_errors(), got_q.size());
    end
    checks++;
    if (!ok || done_at - fetch_at != 54) begin
      failures++;
      $display("[TB] FAIL wrap_latency: got %0d, expected 54", done_at - fetch_at);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int p;
    clear_rec();
    launch(0, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL illegal_count0: got err=%b busy=%b, expected 1/0", err, busy);
    end
    repeat (3) cycle();
    launch(6, 1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL illegal_ptr6: got err=%b busy=%b, expected 1/0", err, busy);
    end
    launch($urandom_range(0, 5), 7);
    repeat (3) cycle();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || mem_reads != 0) begin
      failures++;
      $display("[TB] FAIL illegal_count7: got err=%b busy=%b reads=%0d, expected 1/0/0", err, busy, mem_reads);
    end
    p = $urandom_range(0, 5);
    build_expected(p, 1);
    launch(p, 1);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL illegal_recover: got err=%b busy=%b, expected 0/1", err, busy);
    end
    run_until_done(1, 60, ok);
    checks++;
    if (!ok || stream_errors() != 0) begin
      failures++;
      $display("[TB] FAIL illegal_followup: got ok=%0d bad=%0d, expected 1/0", ok, stream_errors());
    end
  endtask

  task automatic test_stalls();
    int p = $urandom_range(0, 5);
    int cnt = $urandom_range(2, 4);
    clear_rec();
    build_expected(p, cnt);
    launch(p, cnt);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      bus.elem_ready = (i < 8) ? ((i % 4) == 0 || (i % 4) == 3) : ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.elem_ready = 1'b1;
    checks++;
    if (done_cnt != 1 || stream_errors() != 0) begin
      failures++;
      $display("[TB] FAIL stall_stream: got done=%0d bad=%0d elems=%0d, expected 1/0/%0d", done_cnt, stream_errors(), got_q.size(), exp_q.size());
    end
    checks++;
    if (stall_breaks != 0 || stall_cycles == 0) begin
      failures++;
      $display("[TB] FAIL stall_hold: got breaks=%0d stalls=%0d, expected 0 breaks", stall_breaks, stall_cycles);
    end
    checks++;
    if (mem_reads != cnt) begin
      failures++;
      $display("[TB] FAIL stall_reads: got %0d, expected %0d", mem_reads, cnt);
    end
  endtask

  task automatic test_abort();
    bit ok, aborted;
    int p = $urandom_range(0, 5);
    int cnt;
    clear_rec();
    build_expected(p, 2);
    launch(p, 2);
    aborted = 1'b0;
    for (int i = 0; i < 200 && !aborted; i++) begin
      if (got_q.size() == 22 && bus.elem_valid) begin
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        aborted = 1'b1;
      end else begin
        cycle();
      end
    end
    checks++;
    if (!aborted || busy !== 1'b0 || bus.elem_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle: got aborted=%0d busy=%b valid=%b, expected 1/0/0", aborted, busy, bus.elem_valid);
    end
    repeat (20) cycle();
    while (exp_q.size() > 23) begin
      void'(exp_q.pop_back());
      void'(exp_last_q.pop_back());
    end
    checks++;
    if (done_cnt != 0 || err !== 1'b0 || mem_reads != 2 || stream_errors() != 0) begin
      failures++;
      $display("[TB] FAIL abort_effect: got done=%0d err=%b reads=%0d bad=%0d elems=%0d, expected 0/0/2/0/23",
               done_cnt, err, mem_reads, stream_errors(), got_q.size());
    end
    cnt = $urandom_range(1, 3);
    clear_rec();
    build_expected(0, cnt);
    launch(0, cnt);
    run_until_done(1, 200, ok);
    checks++;
    if (!ok || stream_errors() != 0 || ptr_seen.size() == 0 || ptr_seen[0] !== 3'd0) begin
      failures++;
      $display("[TB] FAIL abort_restart: got ok=%0d bad=%0d, expected 1/0", ok, stream_errors());
    end
  endtask

  task automatic test_reset_async();
    bit ok;
    int p = $urandom_range(1, 5);
    clear_rec();
    launch(p, 2);
    cycle();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, bus.mem_read, bus.elem_valid, done, err} !== 5'b0 || bus.mem_pointer !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_in_wait: got flags=%b ptr=%0d, expected 00000/0",
               {busy, bus.mem_read, bus.elem_valid, done, err}, bus.mem_pointer);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    launch($urandom_range(0, 5), 1);
    repeat (7) cycle();
    checks++;
    if (bus.elem_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL prestream: got valid=%b busy=%b, expected 1/1", bus.elem_valid, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, bus.elem_valid, bus.elem_last} !== 3'b0 || bus.elem_out !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_in_stream: got flags=%b elem=%h, expected 000/0000", {busy, bus.elem_valid, bus.elem_last}, bus.elem_out);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    clear_rec();
    build_expected(p, 1);
    launch(p, 1);
    run_until_done(1, 60, ok);
    checks++;
    if (!ok || first_valid - fetch_at != 2 || done_at - fetch_at != 18 || stream_errors() != 0) begin
      failures++;
      $display("[TB] FAIL reset_recover: got ok=%0d valid_lat=%0d done_lat=%0d bad=%0d, expected 1/2/18/0",
               ok, first_valid - fetch_at, done_at - fetch_at, stream_errors());
    end
  endtask

  initial begin
    bus.elem_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) mem[i][32*k +: 32] = $urandom;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_wrap_burst();
    test_illegal();
    test_stalls();
    test_abort();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
